// File: rtl/aig_tt_pkg.sv
// rtl/aig_tt_pkg.sv - shared state type and default widths for the AIG truth-table sweeper
package aig_tt_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, RESP} tt_state_e;

  localparam int N_IN_DEF = 4;
  localparam int IDX_W    = N_IN_DEF;
  localparam int TT_W     = 1 << N_IN_DEF;
  localparam int CNT_W    = N_IN_DEF + 1;

endpackage

// File: rtl/aig_tt_capture_pipe.sv
// rtl/aig_tt_capture_pipe.sv - (valid, index) delay line matching the attached AIG latency
module aig_tt_capture_pipe #(
  parameter int DEPTH = 0,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk | rst;
      assign out_valid      = in_valid;
      assign out_idx        = in_idx;
    end else begin : g_sr
      logic [DEPTH-1:0] vld_q;
      logic [IDX_W-1:0] idx_q [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
          vld_q[0] <= in_valid;
          idx_q[0] <= in_idx;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
          end
        end
      end

      assign out_valid = vld_q[DEPTH-1];
      assign out_idx   = idx_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/aig_tt_sweeper.sv
// rtl/aig_tt_sweeper.sv - drives an AIG through every minterm, captures y0 and checks the truth table
// Optional macro AIG_TT_SWEEPER_YREG_EN registers y0 before capture (one extra cycle of latency).
module aig_tt_sweeper
  import aig_tt_pkg::*;
#(
  parameter int N_IN = IDX_W,
  parameter int LAT  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [(1<<N_IN)-1:0] req_tt_exp,
  output logic [N_IN-1:0]      x,
  input  logic                 y0,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [(1<<N_IN)-1:0] rsp_tt,
  output logic                 rsp_match,
  output logic [N_IN-1:0]      rsp_first_bad,
  output logic [N_IN:0]        rsp_nbad,
  output logic                 busy
);

  localparam int TTW = 1 << N_IN;
  localparam int CW  = N_IN + 1;

  logic y_s;
`ifdef AIG_TT_SWEEPER_YREG_EN
  localparam int EFF_LAT = LAT + 1;
  logic y_q;
  always_ff @(posedge clk) begin
    if (rst) y_q <= 1'b0;
    else     y_q <= y0;
  end
  assign y_s = y_q;
`else
  localparam int EFF_LAT = LAT;
  assign y_s = y0;
`endif

  tt_state_e       state_q;
  logic [N_IN-1:0] x_q;
  logic [TTW-1:0]  exp_q;
  logic [TTW-1:0]  cap_q;
  logic [CW-1:0]   nbad_q;
  logic [N_IN-1:0] fb_q;
  logic            match_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            busy_q;

  logic            cap_vld;
  logic [N_IN-1:0] cap_idx;
  logic            last_cap;
  logic            mis;

  aig_tt_capture_pipe #(
    .DEPTH (EFF_LAT),
    .IDX_W (N_IN)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (state_q == DRIVE),
    .in_idx    (x_q),
    .out_valid (cap_vld),
    .out_idx   (cap_idx)
  );

  assign last_cap = cap_vld && (&cap_idx);
  assign mis      = cap_vld && (y_s != exp_q[cap_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      exp_q       <= '0;
      cap_q       <= '0;
      nbad_q      <= '0;
      fb_q        <= '0;
      match_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Captures arrive in ascending index order, so the first mismatch is the lowest one.
      if (cap_vld) begin
        cap_q[cap_idx] <= y_s;
        if (mis) begin
          nbad_q <= nbad_q + CW'(1);
          if (nbad_q == '0) fb_q <= cap_idx;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            exp_q       <= req_tt_exp;
            cap_q       <= '0;
            nbad_q      <= '0;
            fb_q        <= '0;
            match_q     <= 1'b0;
            x_q         <= '0;
            state_q     <= DRIVE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        DRIVE: begin
          if (&x_q) begin
            x_q <= '0;
            if (EFF_LAT == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              match_q     <= (nbad_q == '0) && !mis;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            x_q <= x_q + N_IN'(1);
          end
        end
        DRAIN: begin
          if (last_cap) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            match_q     <= (nbad_q == '0) && !mis;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign x             = x_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_tt        = cap_q;
  assign rsp_match     = match_q;
  assign rsp_first_bad = fb_q;
  assign rsp_nbad      = nbad_q;
  assign busy          = busy_q;

endmodule
